vctcxo_dac_writer: RTL and testbench
====================================

# vctcxo_dac_writer

Serializes the 16-bit VCTCXO tuning word from the PPS discipline loop into 24-bit AD5662-format SPI frames on the 200 MHz loop clock. It sits directly downstream of the loop filter output, replacing per-DAC auto-SPI shims with one rate-controlled writer. It coalesces updates that arrive during a frame and optionally slew-limits code steps. It reports busy and the last code actually written.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles (≥2); SCLK = clk/(2·CLK_DIV).
- MIN_GAP, 16: clk cycles sync_n held high between frames (≥1).
- RESET_CODE, 16'h7FFF: code written by the power-on frame; reset value of last_code.
- MAX_STEP, 64: max |code change| per frame when slew limiting is compiled in (1..32767).
- clk  in  1  loop clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- dac_code  in  16  requested tuning word.
- dac_load  in  1  single-cycle strobe: request a frame of dac_code.
- auto_en  in  1  when high, dac_code != target requests a frame with no strobe needed.
- sclk  out  1  SPI clock, idles high.
- mosi  out  1  SPI data, MSB first.
- sync_n  out  1  SPI frame select, active low.
- busy  out  1  high from request acceptance through end of gap.
- last_code  out  16  code carried by the most recently completed frame.

## Operation
- States: IDLE, LOAD, SHIFT, GAP.
- Request = dac_load | (auto_en & dac_code != target) | pending. target resets to RESET_CODE.
- Power-on: `pending` resets to 1, so the first frame after rst_n deasserts writes RESET_CODE unclamped.
- IDLE: on request → LOAD. Capture target ← dac_code, except on the power-on frame. Clear pending. Set busy.
- LOAD: compute send code, then load shift register {6'b0, 2'b00 (PD normal), send[15:0]} → SHIFT.
  - Without the slew macro: send = target.
- SHIFT: sync_n low; 24 bits, MSB first.
  - mosi updates on the clk cycle where sclk rises, or at frame start.
  - DAC samples on the sclk falling edge.
  - After the 24th rising edge → GAP; sync_n high; last_code ← send.
- GAP: hold for MIN_GAP cycles → IDLE; busy clears on the IDLE entry cycle.
- A request during LOAD/SHIFT/GAP sets pending. The follow-on frame uses dac_code sampled at its own IDLE→LOAD transition, so multiple requests coalesce into one frame carrying the newest value.
- dac_load and an auto request in the same cycle count as one request.
- Reset mid-frame: all outputs return to reset values immediately (async). The partial frame is abandoned and the DAC discards it because sync_n rises early. After release, the power-on frame is resent.

## Timing
- Reset values: sclk=1, mosi=0, sync_n=1, busy=0, last_code=RESET_CODE, state=IDLE.
- Request seen in cycle N (IDLE):
  - busy=1 at N+1.
  - sync_n=0 and mosi=bit23 at N+2.
- sclk:
  - First falls CLK_DIV cycles after sync_n falls.
  - Toggles every CLK_DIV cycles.
  - 24 falling edges and 24 rising edges per frame.
- sync_n is low for exactly 48·CLK_DIV cycles; it rises in the same cycle as the 24th sclk rise.
- last_code updates in the cycle sync_n rises.
- Request-to-completion latency with no backlog: 2 + 48·CLK_DIV + MIN_GAP cycles to busy low.
  - Defaults: 210 cycles.
- Back-to-back pending frames: sync_n-high gap is MIN_GAP+2 cycles.

## Configuration
- DAC_SLEW_LIMIT_EN defined:
  - LOAD computes d = target − last_code as a 17-bit signed value.
  - send = last_code + clamp(d, −MAX_STEP, +MAX_STEP).
  - The result stays in 0..65535 because it never passes target.
  - At frame end, if send != target, pending is set, so stepping continues autonomously until last_code == target.
  - The power-on frame is exempt.
- DAC_SLEW_LIMIT_EN undefined: send = target always; MAX_STEP is ignored.

## Test plan
- Power-on: release rst_n with defaults → one frame with bits 0x007FFF, sync_n low exactly 192 cycles, last_code=16'h7FFF, busy low at cycle 210.
- Single load: dac_load with dac_code=16'hA5C3 from IDLE → 24 bits 0x00A5C3 sampled on sclk falls, sync_n low 192 cycles, last_code=16'hA5C3.
- Coalescing: during a frame, strobe 16'h1111, 16'h2222, 16'h3333 → exactly one follow-on frame carrying 16'h3333, gap MIN_GAP+2 cycles.
- Auto mode: auto_en=1, change dac_code 16'h7FFF→16'h8000 and hold → exactly one frame; no further frames while dac_code is unchanged.
- Slew (DAC_SLEW_LIMIT_EN, MAX_STEP=64): last_code=16'h7FFF, load 16'h8100 → frames 0x803F, 0x807F, 0x80BF, 0x80FF, 0x8100, then idle.
- Reset mid-frame: assert rst_n low at bit 10 → sync_n=1, sclk=1, mosi=0, busy=0 immediately; after release, a full RESET_CODE frame is sent.

Source files
------------

// File: rtl/vctcxo_dac_writer.sv
// vctcxo_dac_writer
// Serialises the 16-bit VCTCXO tuning word from the PPS discipline loop into
// 24-bit AD5662 SPI frames ({6'b0, PD=2'b00, code[15:0]}, MSB first).
// Requests arriving mid-frame coalesce into one follow-on frame that carries
// the newest dac_code. The first frame after reset always writes RESET_CODE.
// Optional feature: define DAC_SLEW_LIMIT_EN to limit each frame's code step
// to +/-MAX_STEP; the writer then keeps stepping until it reaches the target.
module vctcxo_dac_writer #(
    parameter int          CLK_DIV    = 4,
    parameter int          MIN_GAP    = 16,
    parameter logic [15:0] RESET_CODE = 16'h7FFF,
    parameter int          MAX_STEP   = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_dac_code,
    input  logic        i_dac_load,
    input  logic        i_auto_en,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_sync_n,
    output logic        o_busy,
    output logic [15:0] o_last_code
);

    localparam int                CNT_MAX   = (CLK_DIV > MIN_GAP) ? CLK_DIV : MIN_GAP;
    localparam int                CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(MIN_GAP - 1);
    // 48 sclk transitions per frame; the last one (index 47) is the 24th rise
    localparam logic [5:0]        LAST_EDGE = 6'd47;
    localparam logic signed [16:0] STEP_MAX = 17'(MAX_STEP);
    localparam logic signed [16:0] STEP_MIN = -STEP_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [5:0]        r_edge;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_sync_n;
    logic              r_pending;
    logic              r_por;
    logic [15:0]       r_target;
    logic [15:0]       r_last_code;
    logic [15:0]       r_send;
    logic [22:0]       r_shreg;

    logic              w_new_req;
    logic              w_req;
    logic              w_div_done;
    logic              w_rise;
    logic              w_frame_end;
    logic              w_gap_done;
    logic [15:0]       w_send;
    logic [23:0]       w_frame;

    // Saturate a signed code difference to the permitted per-frame step.
    function automatic logic signed [16:0] sat_step(input logic signed [16:0] d);
        if (d > STEP_MAX) return STEP_MAX;
        if (d < STEP_MIN) return STEP_MIN;
        return d;
    endfunction

    // A strobe and an auto request in the same cycle are one request.
    assign w_new_req   = i_dac_load | (i_auto_en & (i_dac_code != r_target));
    assign w_req       = w_new_req | r_pending;
    assign w_div_done  = (r_state == S_SHIFT) && (r_cnt == DIV_LAST);
    assign w_rise      = w_div_done & ~r_sclk;
    assign w_frame_end = w_rise && (r_edge == LAST_EDGE);
    assign w_gap_done  = (r_state == S_GAP) && (r_cnt == GAP_LAST);

`ifdef DAC_SLEW_LIMIT_EN
    logic signed [16:0] w_diff;
    logic signed [16:0] w_step;
    // Clamped step never overshoots target, so the sum stays in 0..65535.
    assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_last_code});
    assign w_step = sat_step(w_diff);
    assign w_send = r_por ? r_target : 16'($signed({1'b0, r_last_code}) + w_step);
`else
    assign w_send = r_target;
`endif

    assign w_frame = {6'b000000, 2'b00, w_send};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: one LOAD cycle, 48 half-periods of SHIFT, then GAP.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_frame_end) w_state_nxt = S_GAP;
            S_GAP:   if (w_gap_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Frame timing, SPI pins, request bookkeeping and last-written code.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_edge      <= '0;
            r_sclk      <= 1'b1;
            r_mosi      <= 1'b0;
            r_sync_n    <= 1'b1;
            r_pending   <= 1'b1;
            r_por       <= 1'b1;
            r_target    <= RESET_CODE;
            r_last_code <= RESET_CODE;
        end else begin
            if ((r_state == S_SHIFT) || (r_state == S_GAP)) begin
                if (w_div_done || w_gap_done) r_cnt <= '0;
                else                          r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == S_LOAD)  r_edge <= '0;
            else if (w_div_done)    r_edge <= r_edge + 1'b1;

            if (w_div_done) r_sclk <= ~r_sclk;

            // mosi moves only when sclk rises, so it is stable at every fall
            if (r_state == S_LOAD) begin
                r_sync_n <= 1'b0;
                r_mosi   <= w_frame[23];
            end else if (w_frame_end) begin
                r_sync_n    <= 1'b1;
                r_mosi      <= 1'b0;
                r_last_code <= r_send;
            end else if (w_rise) begin
                r_mosi <= r_shreg[22];
            end

            if (r_state == S_IDLE) begin
                if (w_req) r_pending <= 1'b0;
            end else if (w_new_req) begin
                r_pending <= 1'b1;
`ifdef DAC_SLEW_LIMIT_EN
            end else if (w_frame_end && (r_send != r_target)) begin
                r_pending <= 1'b1;
`endif
            end

            // The power-on frame keeps RESET_CODE as its target
            if ((r_state == S_IDLE) && w_req && !r_por) r_target <= i_dac_code;

            if (r_state == S_LOAD) r_por <= 1'b0;
        end
    end

    // Frame data: code being sent and the remaining bits to shift out.
    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD) begin
            r_send  <= w_send;
            r_shreg <= w_frame[22:0];
        end else if (w_rise) begin
            r_shreg <= {r_shreg[21:0], 1'b0};
        end
    end

    assign o_sclk      = r_sclk;
    assign o_mosi      = r_mosi;
    assign o_sync_n    = r_sync_n;
    assign o_busy      = (r_state != S_IDLE);
    assign o_last_code = r_last_code;

endmodule

// File: tb/tb_vctcxo_dac_writer.sv
// Testbench for vctcxo_dac_writer: SPI frames are decoded from the pins and
// compared with an arithmetic model of which codes should be written.
`timescale 1ns/1ps
module tb_vctcxo_dac_writer;

    localparam int          CLK_DIV    = 4;
    localparam int          MIN_GAP    = 16;
    localparam logic [15:0] RESET_CODE = 16'h7FFF;
    localparam int          MAX_STEP   = 64;
    localparam int          FRAME_LOW  = 48 * CLK_DIV;
    localparam int          LATENCY    = 2 + 48 * CLK_DIV + MIN_GAP;
    localparam int          B2B_GAP    = MIN_GAP + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dac_code = 16'h0000;
    logic        dac_load = 1'b0;
    logic        auto_en = 1'b0;
    logic        sclk;
    logic        mosi;
    logic        sync_n;
    logic        busy;
    logic [15:0] last_code;

    vctcxo_dac_writer #(
        .CLK_DIV    (CLK_DIV),
        .MIN_GAP    (MIN_GAP),
        .RESET_CODE (RESET_CODE),
        .MAX_STEP   (MAX_STEP)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_dac_code  (dac_code),
        .i_dac_load  (dac_load),
        .i_auto_en   (auto_en),
        .o_sclk      (sclk),
        .o_mosi      (mosi),
        .o_sync_n    (sync_n),
        .o_busy      (busy),
        .o_last_code (last_code)
    );

    always #2 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame monitor (samples on falling clk edge) ----------
    typedef struct {
        logic [23:0] word;
        int          bits;
        int          low;
        int          gap;
        logic [15:0] last;
    } frame_t;

    frame_t      frames[$];
    logic [23:0] m_word;
    int          m_bits, m_low, m_hi, m_gap;
    logic        m_prev_sclk, m_prev_sync;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_word      <= '0;
            m_bits      <= 0;
            m_low       <= 0;
            m_hi        <= 0;
            m_gap       <= 0;
            m_prev_sclk <= 1'b1;
            m_prev_sync <= 1'b1;
        end else begin
            if (!sync_n) begin
                if (m_prev_sync) begin
                    m_gap <= m_hi;
                    m_hi  <= 0;
                end
                m_low <= m_low + 1;
                if (m_prev_sclk && !sclk) begin
                    m_word <= {m_word[22:0], mosi};
                    m_bits <= m_bits + 1;
                end
            end else begin
                if (!m_prev_sync) begin
                    frames.push_back('{m_word, m_bits, m_low, m_gap, last_code});
                    m_word <= '0;
                    m_bits <= 0;
                    m_low  <= 0;
                end
                m_hi <= m_hi + 1;
            end
            m_prev_sclk <= sclk;
            m_prev_sync <= sync_n;
        end
    end

    // ---------------- reference model: which codes get written ------------
    logic [15:0] mdl_last;
    logic [15:0] exp_q[$];

    task automatic model_load(input logic [15:0] tgt);
        int cur = int'(mdl_last);
        int t   = int'(tgt);
        int d;
        do begin
            d = t - cur;
`ifdef DAC_SLEW_LIMIT_EN
            if (d > MAX_STEP) d = MAX_STEP;
            else if (d < -MAX_STEP) d = -MAX_STEP;
`endif
            cur = cur + d;
            exp_q.push_back(16'(cur));
        end while (cur != t);
        mdl_last = tgt;
    endtask

    task automatic model_auto(input logic [15:0] tgt);
        if (tgt != mdl_last) model_load(tgt);
    endtask

    task automatic check_frames(input string name);
        frame_t      f;
        logic [15:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (frames.size() == 0) begin
                check($sformatf("%s frame present for %h", name, e), 0, 1);
            end else begin
                f = frames.pop_front();
                check($sformatf("%s word", name), 32'(f.word), {8'h00, 8'h00, e});
                check($sformatf("%s bits", name), f.bits, 24);
                check($sformatf("%s sync_n low cycles", name), f.low, FRAME_LOW);
                check($sformatf("%s last_code", name), 32'(f.last), 32'(e));
            end
        end
        check($sformatf("%s extra frames", name), frames.size(), 0);
    endtask

    // ---------------- stimulus helpers ------------------------------------
    task automatic run_load(input logic [15:0] code, output int lat);
        bit seen = 1'b0;
        @(negedge clk);
        dac_code = code;
        dac_load = 1'b1;
        lat = 0;
        for (int k = 1; k <= 60000; k++) begin
            @(posedge clk);
            #1;
            dac_load = 1'b0;
            if (busy) seen = 1'b1;
            else if (seen) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_release(output int lat);
        bit seen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 2000; k++) begin
            @(posedge clk);
            #1;
            if (busy) seen = 1'b1;
            else if (seen) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int low = 0;
        for (int k = 0; (k < 60000) && (low < 4); k++) begin
            @(posedge clk);
            #1;
            low = busy ? 0 : low + 1;
        end
        check($sformatf("%s reached idle", name), 32'(low >= 4), 1);
    endtask

    typedef struct {
        logic [15:0] code;
        logic [23:0] exp_word;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        logic [15:0] co[4];
        logic [15:0] c;
        int          lat;
        bit          use_auto;

`ifdef DAC_SLEW_LIMIT_EN
        tbl[0] = '{16'h8000, 24'h008000};
        tbl[1] = '{16'h8040, 24'h008040};
        tbl[2] = '{16'h8000, 24'h008000};
        tbl[3] = '{16'h7FC0, 24'h007FC0};
        tbl[4] = '{16'h7FFF, 24'h007FFF};
        co[0] = 16'h8010; co[1] = 16'h8011; co[2] = 16'h8022; co[3] = 16'h8033;
`else
        tbl[0] = '{16'hA5C3, 24'h00A5C3};
        tbl[1] = '{16'h0000, 24'h000000};
        tbl[2] = '{16'hFFFF, 24'h00FFFF};
        tbl[3] = '{16'h0001, 24'h000001};
        tbl[4] = '{16'h7FFF, 24'h007FFF};
        co[0] = 16'h0F0F; co[1] = 16'h1111; co[2] = 16'h2222; co[3] = 16'h3333;
`endif

        // reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset sclk", 32'(sclk), 1);
        check("reset mosi", 32'(mosi), 0);
        check("reset sync_n", 32'(sync_n), 1);
        check("reset busy", 32'(busy), 0);
        check("reset last_code", 32'(last_code), 32'(RESET_CODE));

        // power-on frame
        mdl_last = RESET_CODE;
        run_release(lat);
        check("power-on latency", lat, LATENCY);
        exp_q.push_back(RESET_CODE);
        check_frames("power-on");

        // table-driven single loads from idle
        for (int i = 0; i < 5; i++) begin
            run_load(tbl[i].code, lat);
            wait_idle($sformatf("vec%0d", i));
            check($sformatf("vec%0d latency", i), lat, LATENCY);
            check($sformatf("vec%0d frame count", i), frames.size(), 1);
            if (frames.size() > 0) begin
                check($sformatf("vec%0d word", i), 32'(frames[0].word), 32'(tbl[i].exp_word));
                check($sformatf("vec%0d low", i), frames[0].low, FRAME_LOW);
                void'(frames.pop_front());
            end
            check($sformatf("vec%0d last_code", i), 32'(last_code), 32'(tbl[i].code));
            frames.delete();
            mdl_last = tbl[i].code;
        end

        // coalescing: three strobes during one frame -> one follow-on frame
        @(negedge clk);
        dac_code = co[0];
        dac_load = 1'b1;
        @(negedge clk);
        dac_load = 1'b0;
        repeat (20) @(negedge clk);
        for (int j = 1; j < 4; j++) begin
            dac_code = co[j];
            dac_load = 1'b1;
            @(negedge clk);
            dac_load = 1'b0;
            repeat (10) @(negedge clk);
        end
        wait_idle("coalesce");
        check("coalesce frame count", frames.size(), 2);
        if (frames.size() >= 2) check("coalesce gap", frames[1].gap, B2B_GAP);
        model_load(co[0]);
        model_load(co[3]);
        check_frames("coalesce");

        // auto mode: one frame per change, none while the code holds
        @(negedge clk);
        dac_code = 16'h7FFF;
        auto_en  = 1'b1;
        wait_idle("auto pre");
        model_auto(16'h7FFF);
        check_frames("auto pre");
        @(negedge clk);
        dac_code = 16'h8000;
        wait_idle("auto step");
        repeat (300) @(negedge clk);
        model_auto(16'h8000);
        check_frames("auto step");
        auto_en = 1'b0;

        // randomized loads / auto updates against the model
        for (int i = 0; i < 8; i++) begin
`ifdef DAC_SLEW_LIMIT_EN
            c = 16'(int'(mdl_last) + int'($urandom_range(0, 400)) - 200);
`else
            c = 16'($urandom);
`endif
            if (i == 3) c = mdl_last;
            use_auto = 1'($urandom_range(0, 1));
            if (use_auto) begin
                @(negedge clk);
                dac_code = c;
                auto_en  = 1'b1;
                repeat (20) @(negedge clk);
                wait_idle($sformatf("rand%0d", i));
                @(negedge clk);
                auto_en = 1'b0;
                model_auto(c);
            end else begin
                run_load(c, lat);
                wait_idle($sformatf("rand%0d", i));
                model_load(c);
            end
            check_frames($sformatf("rand%0d", i));
        end

`ifdef DAC_SLEW_LIMIT_EN
        // slew stepping from 7FFF to 8100
        run_load(16'h7FFF, lat);
        wait_idle("slew return");
        model_load(16'h7FFF);
        check_frames("slew return");
        run_load(16'h8100, lat);
        wait_idle("slew");
        exp_q.push_back(16'h803F);
        exp_q.push_back(16'h807F);
        exp_q.push_back(16'h80BF);
        exp_q.push_back(16'h80FF);
        exp_q.push_back(16'h8100);
        mdl_last = 16'h8100;
        check_frames("slew");
`endif

        // reset in the middle of a frame
        @(negedge clk);
        dac_code = 16'h1234;
        dac_load = 1'b1;
        @(negedge clk);
        dac_load = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (m_bits >= 10) break;
        end
        check("midrst reached bit 10", 32'(m_bits >= 10), 1);
        check("midrst sync_n low before reset", 32'(sync_n), 0);
        rst_n = 1'b0;
        #1;
        check("midrst sync_n", 32'(sync_n), 1);
        check("midrst sclk", 32'(sclk), 1);
        check("midrst mosi", 32'(mosi), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst last_code", 32'(last_code), 32'(RESET_CODE));
        frames.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        mdl_last = RESET_CODE;
        run_release(lat);
        check("post-reset latency", lat, LATENCY);
        wait_idle("post-reset");
        exp_q.push_back(RESET_CODE);
        check_frames("post-reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
